// File: rtl/bg_effect_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bg_effect_pkg                                                      |
// | Shared state and effect-code definitions for background effects.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bg_effect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ICE  = 2'd1,
    BOOM = 2'd2
  } effect_state_t;

  localparam logic [1:0] EFFECT_NONE = 2'd0;
  localparam logic [1:0] EFFECT_ICE  = 2'd1;
  localparam logic [1:0] EFFECT_BOOM = 2'd2;

endpackage
`default_nettype wire

// File: rtl/effect_frame_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | effect_frame_timer                                                 |
// | Loadable frame down-counter with freeze; flags its final frame.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module effect_frame_timer #(
  parameter int unsigned MAX_COUNT = 1,
  parameter int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic load,
  input  logic freeze,
  input  logic tick,
  output logic last
);

  logic [WIDTH-1:0] r_count;

  // Load beats decrement, and the count holds at 1 so it can never wrap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= WIDTH'(MAX_COUNT);
    end else if (tick && !freeze && (r_count > WIDTH'(1))) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign last = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/background_effect_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | background_effect_scheduler                                        |
// | Frame-timed Ice/Boom enable windows; Boom preempts, Ice resumes.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module background_effect_scheduler
  import bg_effect_pkg::*;
#(
  parameter int unsigned ICE_FRAMES   = 120,
  parameter int unsigned BOOM_FRAMES  = 30,
  parameter int unsigned BLINK_PERIOD = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       iceEvent,
  input  logic       boomEvent,
  input  logic       clearEffects,
  output logic       iceEnable,
  output logic       boomEnable,
  output logic [1:0] effectCode,
  output logic       busy
);

  effect_state_t r_state, w_state_nxt;
  logic r_ice_pending, w_ice_pending_nxt;
  logic r_blink_phase, w_blink_phase_nxt;

  logic w_ice_clr, w_ice_load, w_ice_tick, w_ice_last;
  logic w_boom_clr, w_boom_load, w_boom_tick, w_boom_last;
  logic w_blink_clr, w_blink_load, w_blink_tick, w_blink_last;
  logic w_ice_en, w_boom_en, w_busy;
  logic [1:0] w_code;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= IDLE;
      r_ice_pending <= 1'b0;
      r_blink_phase <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ice_pending <= w_ice_pending_nxt;
      r_blink_phase <= w_blink_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_ice_pending_nxt = r_ice_pending;
    w_blink_phase_nxt = r_blink_phase;
    w_ice_clr   = 1'b0; w_ice_load   = 1'b0; w_ice_tick   = 1'b0;
    w_boom_clr  = 1'b0; w_boom_load  = 1'b0; w_boom_tick  = 1'b0;
    w_blink_clr = 1'b0; w_blink_load = 1'b0; w_blink_tick = 1'b0;
    if (clearEffects) begin
      w_state_nxt       = IDLE;
      w_ice_pending_nxt = 1'b0;
      w_blink_phase_nxt = 1'b0;
      w_ice_clr   = 1'b1;
      w_boom_clr  = 1'b1;
      w_blink_clr = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (boomEvent) begin
            w_state_nxt       = BOOM;
            w_boom_load       = 1'b1;
            w_blink_load      = 1'b1;
            w_blink_phase_nxt = 1'b1;
            if (iceEvent) begin
              w_ice_pending_nxt = 1'b1;
              w_ice_load        = 1'b1;
            end
          end else if (iceEvent) begin
            w_state_nxt = ICE;
            w_ice_load  = 1'b1;
          end
        end
        ICE: begin
          if (boomEvent) begin
            // Ice count is frozen while Boom runs unless a fresh iceEvent reloads it.
            w_state_nxt       = BOOM;
            w_boom_load       = 1'b1;
            w_blink_load      = 1'b1;
            w_blink_phase_nxt = 1'b1;
            w_ice_pending_nxt = 1'b1;
            w_ice_load        = iceEvent;
          end else if (iceEvent) begin
            w_ice_load = 1'b1;
          end else if (startOfFrame) begin
            if (w_ice_last) begin
              w_state_nxt = IDLE;
              w_ice_clr   = 1'b1;
            end else begin
              w_ice_tick = 1'b1;
            end
          end
        end
        BOOM: begin
          if (iceEvent) begin
            w_ice_pending_nxt = 1'b1;
            w_ice_load        = 1'b1;
          end
          if (boomEvent) begin
            w_boom_load       = 1'b1;
            w_blink_load      = 1'b1;
            w_blink_phase_nxt = 1'b1;
          end else if (startOfFrame) begin
            if (w_boom_last) begin
              w_boom_clr        = 1'b1;
              w_blink_clr       = 1'b1;
              w_blink_phase_nxt = 1'b0;
              if (r_ice_pending || iceEvent) begin
                w_state_nxt       = ICE;
                w_ice_pending_nxt = 1'b0;
              end else begin
                w_state_nxt = IDLE;
              end
            end else begin
              w_boom_tick = 1'b1;
              if (w_blink_last) begin
                w_blink_load      = 1'b1;
                w_blink_phase_nxt = ~r_blink_phase;
              end else begin
                w_blink_tick = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state values so they register alongside the state.
  always_comb begin
    w_ice_en  = (w_state_nxt == ICE);
    w_boom_en = (w_state_nxt == BOOM) && w_blink_phase_nxt;
    w_busy    = (w_state_nxt != IDLE) || w_ice_pending_nxt;
    w_code    = (w_state_nxt == BOOM) ? EFFECT_BOOM :
                (w_state_nxt == ICE)  ? EFFECT_ICE  : EFFECT_NONE;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      iceEnable  <= 1'b0;
      boomEnable <= 1'b0;
      effectCode <= EFFECT_NONE;
      busy       <= 1'b0;
    end else begin
      iceEnable  <= w_ice_en;
      boomEnable <= w_boom_en;
      effectCode <= w_code;
      busy       <= w_busy;
    end
  end

  effect_frame_timer #(.MAX_COUNT(ICE_FRAMES)) u_ice_timer (
    .clk(clk), .resetN(resetN), .clear(w_ice_clr), .load(w_ice_load),
    .freeze(r_state == BOOM), .tick(w_ice_tick), .last(w_ice_last)
  );

  effect_frame_timer #(.MAX_COUNT(BOOM_FRAMES)) u_boom_timer (
    .clk(clk), .resetN(resetN), .clear(w_boom_clr), .load(w_boom_load),
    .freeze(1'b0), .tick(w_boom_tick), .last(w_boom_last)
  );

  effect_frame_timer #(.MAX_COUNT(BLINK_PERIOD)) u_blink_timer (
    .clk(clk), .resetN(resetN), .clear(w_blink_clr), .load(w_blink_load),
    .freeze(1'b0), .tick(w_blink_tick), .last(w_blink_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_background_effect_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_background_effect_scheduler                                     |
// | Directed bench; observed word is {iceEnable,boomEnable,code,busy}. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_background_effect_scheduler;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       iceEvent = 1'b0;
  logic       boomEvent = 1'b0;
  logic       clearEffects = 1'b0;
  logic       iceEnable, boomEnable, busy;
  logic [1:0] effectCode;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] c_OFF    = 5'b0_0_00_0;
  localparam logic [4:0] c_ICE    = 5'b1_0_01_1;
  localparam logic [4:0] c_BOOM_1 = 5'b0_1_10_1;
  localparam logic [4:0] c_BOOM_0 = 5'b0_0_10_1;

  background_effect_scheduler #(
    .ICE_FRAMES(3), .BOOM_FRAMES(4), .BLINK_PERIOD(2)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .iceEvent(iceEvent), .boomEvent(boomEvent), .clearEffects(clearEffects),
    .iceEnable(iceEnable), .boomEnable(boomEnable),
    .effectCode(effectCode), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs();
    return {iceEnable, boomEnable, effectCode, busy};
  endfunction

  // One clock with the given inputs held across the edge; sampled 1ns after it.
  task automatic cyc(input logic s, input logic i, input logic b, input logic c);
    startOfFrame = s; iceEvent = i; boomEvent = b; clearEffects = c;
    @(posedge clk); #1;
    startOfFrame = 0; iceEvent = 0; boomEvent = 0; clearEffects = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_value("reset", obs(), c_OFF);
    resetN = 1'b1;
    cyc(1, 0, 0, 0);
    check_value("idle_sof", obs(), c_OFF);

    // Ice alone lasts three frame pulses
    cyc(0, 1, 0, 0); check_value("ice_start", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("ice_f1", obs(), c_ICE);
    cyc(0, 0, 0, 0); check_value("ice_hold", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("ice_f2", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("ice_end", obs(), c_OFF);

    // Boom alone blinks 1,1,0,0
    cyc(0, 0, 1, 0); check_value("boom_fr1", obs(), c_BOOM_1);
    cyc(1, 0, 0, 0); check_value("boom_fr2", obs(), c_BOOM_1);
    cyc(1, 0, 0, 0); check_value("boom_fr3", obs(), c_BOOM_0);
    cyc(1, 0, 0, 0); check_value("boom_fr4", obs(), c_BOOM_0);
    cyc(1, 0, 0, 0); check_value("boom_end", obs(), c_OFF);

    // Boom preempts Ice; Ice resumes with two frames left
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); check_value("pre_ice", obs(), c_ICE);
    cyc(0, 0, 1, 0); check_value("preempt", obs(), c_BOOM_1);
    repeat (3) cyc(1, 0, 0, 0);
    check_value("preempt_f3", obs(), c_BOOM_0);
    cyc(1, 0, 0, 0); check_value("resume", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("resume_f1", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("resume_end", obs(), c_OFF);

    // Simultaneous events: Boom first, then full Ice
    cyc(0, 1, 1, 0); check_value("both_boom", obs(), c_BOOM_1);
    repeat (4) cyc(1, 0, 0, 0);
    check_value("both_ice", obs(), c_ICE);
    repeat (2) cyc(1, 0, 0, 0);
    check_value("both_ice_f2", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("both_end", obs(), c_OFF);

    // Boom restart coincident with last frame pulse
    cyc(0, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 0);
    check_value("boom_last", obs(), c_BOOM_0);
    cyc(1, 0, 1, 0); check_value("boom_reload", obs(), c_BOOM_1);
    repeat (3) cyc(1, 0, 0, 0);
    check_value("reload_f3", obs(), c_BOOM_0);
    cyc(1, 0, 0, 0); check_value("reload_end", obs(), c_OFF);

    // Ice restart coincident with last frame pulse
    cyc(0, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0); check_value("ice_reload", obs(), c_ICE);
    repeat (2) cyc(1, 0, 0, 0);
    check_value("ice_reload_f2", obs(), c_ICE);
    cyc(1, 0, 0, 0); check_value("ice_reload_end", obs(), c_OFF);

    // clearEffects with Ice pending under Boom
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0); check_value("pend_boom", obs(), c_BOOM_1);
    cyc(0, 1, 1, 1); check_value("clear", obs(), c_OFF);
    cyc(1, 0, 0, 0); check_value("clear_sof", obs(), c_OFF);
    repeat (4) cyc(1, 0, 0, 0);
    check_value("clear_no_resume", obs(), c_OFF);

    // Asynchronous reset mid-Ice
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0); check_value("pre_rst", obs(), c_ICE);
    #2 resetN = 1'b0;
    #1 check_value("async_rst", obs(), c_OFF);
    @(posedge clk); #1;
    resetN = 1'b1;
    cyc(1, 0, 0, 0); check_value("rst_sof", obs(), c_OFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
